change_dispenser: RTL and testbench

Back end of the vending machine's change path. The vending machine decides a change amount (coin_change, 0..127). This block turns that amount into a sequence of single-coin eject requests to the coin hopper, using denominations 20/10/5/1 in greedy order. It tracks per-denomination coin inventory and reports any amount it could not pay out.

---
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 tb/tb_change_dispenser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// change_dispenser : greedy 20/10/5/1 coin payout with per-coin inventory
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter int VAL_W    = 7,
  parameter int CNT_W    = 6,
  parameter int INIT_C20 = 15,
  parameter int INIT_C10 = 15,
  parameter int INIT_C5  = 15,
  parameter int INIT_C1  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [VAL_W-1:0] change_amt,
  output logic             eject_o,
  output logic [1:0]       eject_den,
  input  logic             eject_ack,
  input  logic             refill_en,
  input  logic [1:0]       refill_den,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic [CNT_W-1:0] cnt_20,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_1,
  output logic             busy,
  output logic             done_o,
  output logic             short_o,
  output logic [VAL_W-1:0] remaining,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EJECT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  function automatic logic [VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    return VAL_W'(1);
      2'd1:    return VAL_W'(5);
      2'd2:    return VAL_W'(10);
      default: return VAL_W'(20);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] init_count(input int idx);
    case (idx)
      0:       return CNT_W'(INIT_C1);
      1:       return CNT_W'(INIT_C5);
      2:       return CNT_W'(INIT_C10);
      default: return CNT_W'(INIT_C20);
    endcase
  endfunction

  state_t           r_state, w_next;
  logic [VAL_W-1:0] r_rem, w_rem_next;
  logic [1:0]       r_den, w_den_next;
  logic             r_eject, r_done, r_short, r_busy;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W:0]   w_sum [4];
  logic [CNT_W-1:0] w_cnt_next [4];
  logic [3:0]       w_dec;
  logic             w_sel_found;
  logic [1:0]       w_sel_den;

  // Ascending scan: the last eligible hit is the largest denomination.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_den   = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if (r_cnt[d] != '0 && coin_value(2'(d)) <= r_rem) begin
        w_sel_found = 1'b1;
        w_sel_den   = 2'(d);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rem_next = r_rem;
    w_den_next = r_den;
    w_dec      = '0;
    case (r_state)
      S_IDLE: begin
        if (change_valid) begin
          w_rem_next = change_amt;
          w_next     = (change_amt == '0) ? S_FINISH : S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_sel_found) begin
          w_next     = S_EJECT;
          w_den_next = w_sel_den;
        end else begin
          w_next = S_FINISH;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          w_rem_next   = r_rem - coin_value(r_den);
          w_dec[r_den] = 1'b1;
          w_next       = (w_rem_next == '0) ? S_FINISH : S_SELECT;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Refill saturates first; a same-cycle payout then takes its coin off the result.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_sum[i] = {1'b0, r_cnt[i]};
      if (refill_en && refill_den == 2'(i))
        w_sum[i] = w_sum[i] + {1'b0, refill_cnt};
      w_cnt_next[i] = (w_sum[i][CNT_W] ? c_cnt_max : w_sum[i][CNT_W-1:0])
                      - CNT_W'(w_dec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_den   <= 2'd0;
      r_eject <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= init_count(i);
    end else begin
      r_state <= w_next;
      r_rem   <= w_rem_next;
      r_den   <= w_den_next;
      r_eject <= (w_next == S_EJECT);
      r_done  <= (w_next == S_FINISH);
      r_short <= (w_next == S_FINISH) && (w_rem_next != '0);
      r_busy  <= (w_next != S_IDLE);
      for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  assign eject_o   = r_eject;
  assign eject_den = r_den;
  assign done_o    = r_done;
  assign short_o   = r_short;
  assign busy      = r_busy;
  assign remaining = r_rem;
  assign state_o   = r_state;
  assign cnt_1     = r_cnt[0];
  assign cnt_5     = r_cnt[1];
  assign cnt_10    = r_cnt[2];
  assign cnt_20    = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_change_dispenser : directed scoreboard bench, three inventory setups
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_change_dispenser;
  localparam int VAL_W = 7;
  localparam int CNT_W = 6;
  localparam int VALS [4] = '{1, 5, 10, 20};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cv [3];
  logic [VAL_W-1:0] amt [3];
  logic             ack [3];
  logic             ref_en [3];
  logic [1:0]       ref_den [3];
  logic [CNT_W-1:0] ref_cnt [3];
  logic             eo [3];
  logic [1:0]       eden [3];
  logic [CNT_W-1:0] c20 [3], c10 [3], c5 [3], c1 [3];
  logic             bsy [3], dn [3], sh [3];
  logic [VAL_W-1:0] rem [3];
  logic [1:0]       st [3];

  // Instance 0: full inventory, 1: no 20-coins, 2: no 1-coins.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    change_dispenser #(
      .VAL_W(VAL_W), .CNT_W(CNT_W),
      .INIT_C20(g == 1 ? 0 : 15), .INIT_C10(15), .INIT_C5(15),
      .INIT_C1(g == 2 ? 0 : 15)
    ) u_dut (
      .clk(clk), .rst(rst),
      .change_valid(cv[g]), .change_amt(amt[g]),
      .eject_o(eo[g]), .eject_den(eden[g]), .eject_ack(ack[g]),
      .refill_en(ref_en[g]), .refill_den(ref_den[g]), .refill_cnt(ref_cnt[g]),
      .cnt_20(c20[g]), .cnt_10(c10[g]), .cnt_5(c5[g]), .cnt_1(c1[g]),
      .busy(bsy[g]), .done_o(dn[g]), .short_o(sh[g]),
      .remaining(rem[g]), .state_o(st[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int exp_q [$];
  int exp_rem;
  int exp_short;
  int m_cnt [3][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy reference: fills the scoreboard and updates the model inventory.
  task automatic plan(input int i, input int a);
    int r;
    int f;
    r = a;
    exp_q.delete();
    while (r > 0) begin
      f = -1;
      for (int d = 3; d >= 0; d--)
        if (f < 0 && VALS[d] <= r && m_cnt[i][d] > 0) f = d;
      if (f < 0) break;
      exp_q.push_back(f);
      r = r - VALS[f];
      m_cnt[i][f] = m_cnt[i][f] - 1;
    end
    exp_rem   = r;
    exp_short = (r != 0) ? 1 : 0;
  endtask

  task automatic chk_counts(input int i);
    chk("cnt_20", c20[i], m_cnt[i][3]);
    chk("cnt_10", c10[i], m_cnt[i][2]);
    chk("cnt_5",  c5[i],  m_cnt[i][1]);
    chk("cnt_1",  c1[i],  m_cnt[i][0]);
  endtask

  task automatic run(input int i, input int a, input int dly, input bit mid,
                     input bit refat, input int exp_cyc);
    int k, obs, coin;
    bit seen_done;
    plan(i, a);
    @(negedge clk);
    cv[i] = 1'b1; amt[i] = VAL_W'(a); ack[i] = 1'b1;
    k = 0; obs = 0; coin = 0; seen_done = 1'b0;
    while (!seen_done && k < 200) begin
      @(negedge clk);
      k++;
      cv[i] = 1'b0;
      ref_en[i] = 1'b0;
      if (k == 1) chk("busy_start", bsy[i], 1);
      if (mid && coin == 0 && obs == 1) begin
        cv[i] = 1'b1; amt[i] = VAL_W'(50);
      end
      if (eo[i]) begin
        obs++;
        chk("coins_left", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) chk("eject_den", eden[i], exp_q[0]);
        ack[i] = (coin > 0 || obs > dly);
        if (ack[i]) begin
          if (coin == 0 && dly > 0) chk("hold_cycles", obs, dly + 1);
          if (coin == 0 && refat) begin
            ref_en[i] = 1'b1; ref_den[i] = 2'd0; ref_cnt[i] = CNT_W'(5);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          coin++;
          obs = 0;
        end
      end else begin
        ack[i] = 1'b1;
      end
      if (dn[i]) seen_done = 1'b1;
    end
    chk("done_seen", seen_done, 1);
    chk("done_cycle", k, exp_cyc);
    chk("short", sh[i], exp_short);
    chk("remaining", rem[i], exp_rem);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", dn[i], 0);
    chk("busy_end", bsy[i], 0);
    @(negedge clk);
    chk("idle_after", st[i], 0);
    chk_counts(i);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cv[i] = 1'b0; amt[i] = '0; ack[i] = 1'b1;
      ref_en[i] = 1'b0; ref_den[i] = 2'd0; ref_cnt[i] = '0;
      for (int d = 0; d < 4; d++) m_cnt[i][d] = 15;
    end
    m_cnt[1][3] = 0;
    m_cnt[2][0] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_eject", eo[0], 0);
    chk("rst_den", eden[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_short", sh[0], 0);
    chk("rst_rem", rem[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_state", st[0], 0);
    chk_counts(0);

    // 38 = 20+10+5+1+1+1, all inventory available
    run(0, 38, 0, 1'b0, 1'b0, 13);
    chk("t1_c20", c20[0], 14);
    chk("t1_c1", c1[0], 12);
    // zero amount: straight to FINISH
    run(0, 0, 0, 1'b0, 1'b0, 1);
    // no 20-coins: 25 = 10+10+5
    run(1, 25, 0, 1'b0, 1'b0, 7);
    chk("t3_c10", c10[1], 13);
    // no 1-coins: 7 leaves 2 unpaid
    run(2, 7, 0, 1'b0, 1'b0, 4);
    chk("t4_rem", rem[2], 2);
    chk("t4_c5", c5[2], 14);
    // slow hopper on first coin plus an ignored mid-payout request
    run(0, 30, 3, 1'b1, 1'b0, 8);

    // reset while a coin is being ejected
    @(negedge clk);
    cv[0] = 1'b1; amt[0] = VAL_W'(38); ack[0] = 1'b0;
    @(negedge clk);
    cv[0] = 1'b0;
    k = 0;
    while (!eo[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_eject", eo[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack[0] = 1'b1;
    chk("mid_rst_eject", eo[0], 0);
    chk("mid_rst_state", st[0], 0);
    chk("mid_rst_den", eden[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    for (int d = 0; d < 4; d++) m_cnt[0][d] = 15;
    for (int d = 0; d < 4; d++) m_cnt[1][d] = 15;
    for (int d = 0; d < 4; d++) m_cnt[2][d] = 15;
    m_cnt[1][3] = 0;
    m_cnt[2][0] = 0;
    chk_counts(0);

    // refill saturation: 15 + 60 clips at 63
    ref_en[0] = 1'b1; ref_den[0] = 2'd0; ref_cnt[0] = CNT_W'(60);
    @(negedge clk);
    ref_en[0] = 1'b0;
    chk("refill_sat", c1[0], 63);
    m_cnt[0][0] = 63;

    // refill and payout of the same coin in one cycle: sat(63+5)-1
    run(0, 1, 0, 1'b0, 1'b1, 3);
    chk("refill_dec", c1[0], 62);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
